aes_spi_link: RTL and testbench

SPI slave link between the MCU and the AES core. Oversamples the MCU's SPI lines in the system clock domain and shifts in a 128-bit key and a 128-bit plaintext. It then pulses the core to start, captures the 128-bit ciphertext when the core finishes, and shifts it back to the MCU MSB first. It sits directly downstream of the state-to-output flattening stage, which supplies `cyphertext`, and directly upstream of the core's key/plaintext inputs.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_spi_link_sync_edge.sv | 32 +++
 rtl/aes_spi_link.sv | 171 +++++++++++++++++
 tb/tb_aes_spi_link.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES SPI link.
// Block width and link state encoding.
package aes_pkg;

  localparam int BLOCK_BITS = 128;
  localparam int RX_BITS    = 2 * BLOCK_BITS;
  localparam int CNT_W      = $clog2(RX_BITS) + 1;
  localparam int TXC_W      = $clog2(BLOCK_BITS);

  typedef enum logic [1:0] {
    IDLE,
    RX,
    WAIT,
    TX
  } link_state_t;

endpackage

// File: rtl/aes_spi_link_sync_edge.sv
// Two-flop synchroniser with an edge register.
// Provides the synced level plus one-cycle rise/fall strobes.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/aes_spi_link.sv
// SPI slave link: shifts key+plaintext in, starts the core,
// and shifts the captured ciphertext back out MSB first.
module aes_spi_link
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  sdi,
  input  logic                  load,
  output logic                  sdo,
  output logic                  done_out,
  output logic                  err,
  output logic [BLOCK_BITS-1:0] key,
  output logic [BLOCK_BITS-1:0] plaintext,
  output logic                  start,
  input  logic                  core_done,
  input  logic [BLOCK_BITS-1:0] cyphertext
);

  logic sck_lvl, sck_rise, sck_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic ld_lvl, ld_rise, ld_fall;

  sync_edge u_sck (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (sck),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge u_sdi (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (sdi),
    .level (sdi_lvl),
    .rise  (sdi_rise),
    .fall  (sdi_fall)
  );

  sync_edge u_load (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (load),
    .level (ld_lvl),
    .rise  (ld_rise),
    .fall  (ld_fall)
  );

  wire unused_ok = &{1'b0, sck_lvl, sdi_rise, sdi_fall, ld_lvl};

  link_state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [TXC_W-1:0]      tx_cnt_q;
  logic [RX_BITS-1:0]    sr_q;
  logic [BLOCK_BITS-1:0] tx_q;

  logic go_rx, shift_rx, commit, bad;
  logic ld_tx, shift_tx, tx_end;

  wire rx_full = (cnt_q == CNT_W'(RX_BITS));
  wire tx_last = (tx_cnt_q == TXC_W'(BLOCK_BITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // load events are checked before sck so they win a same-cycle tie
  always_comb begin
    state_d  = state_q;
    go_rx    = 1'b0;
    shift_rx = 1'b0;
    commit   = 1'b0;
    bad      = 1'b0;
    ld_tx    = 1'b0;
    shift_tx = 1'b0;
    tx_end   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_rise) begin
          go_rx   = 1'b1;
          state_d = RX;
        end
      end
      RX: begin
        if (ld_fall) begin
          if (rx_full) begin
            commit  = 1'b1;
            state_d = WAIT;
          end else begin
            bad     = 1'b1;
            state_d = IDLE;
          end
        end else if (sck_rise) begin
          shift_rx = 1'b1;
        end
      end
      WAIT: begin
        if (ld_rise) begin
          go_rx   = 1'b1;
          state_d = RX;
        end else if (core_done) begin
          ld_tx   = 1'b1;
          state_d = TX;
        end
      end
      TX: begin
        if (ld_rise) begin
          go_rx   = 1'b1;
          state_d = RX;
        end else if (sck_fall) begin
          shift_tx = 1'b1;
          if (tx_last) begin
            tx_end  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      tx_cnt_q  <= '0;
      sr_q      <= '0;
      tx_q      <= '0;
      key       <= '0;
      plaintext <= '0;
      start     <= 1'b0;
      done_out  <= 1'b0;
      err       <= 1'b0;
    end else begin
      start <= commit;
      if (go_rx) begin
        cnt_q    <= '0;
        tx_cnt_q <= '0;
        tx_q     <= '0;
        err      <= 1'b0;
        done_out <= 1'b0;
      end
      if (shift_rx) begin
        sr_q <= {sr_q[RX_BITS-2:0], sdi_lvl};
        if (!rx_full) cnt_q <= cnt_q + 1'b1;
      end
      if (commit) begin
        key       <= sr_q[RX_BITS-1:BLOCK_BITS];
        plaintext <= sr_q[BLOCK_BITS-1:0];
      end
      if (bad) err <= 1'b1;
      if (ld_tx) begin
        tx_q     <= cyphertext;
        tx_cnt_q <= '0;
        done_out <= 1'b1;
      end
      if (shift_tx) begin
        tx_q     <= {tx_q[BLOCK_BITS-2:0], 1'b0};
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
      if (tx_end) done_out <= 1'b0;
    end
  end

  // emptied register shifts in zeros, so extra sck edges read 0
  assign sdo = tx_q[BLOCK_BITS-1];

endmodule

// File: tb/tb_aes_spi_link.sv
// Scoreboard bench for aes_spi_link: directed SPI loads,
// a simple core model and a monitor checking start/readout.
module tb_aes_spi_link;
  import aes_pkg::*;

  logic clk;
  logic reset_n;
  logic sck, sdi, load;
  logic sdo, done_out, err, start;
  logic core_done;
  logic [BLOCK_BITS-1:0] key, plaintext;
  logic [BLOCK_BITS-1:0] cyphertext, core_ct;

  int total = 0;
  int bad   = 0;

  logic [RX_BITS-1:0]    exp_start_q[$];
  logic [BLOCK_BITS-1:0] exp_ct_q[$];
  logic [BLOCK_BITS-1:0] got_q[$];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

  aes_spi_link dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sck        (sck),
    .sdi        (sdi),
    .load       (load),
    .sdo        (sdo),
    .done_out   (done_out),
    .err        (err),
    .key        (key),
    .plaintext  (plaintext),
    .start      (start),
    .core_done  (core_done),
    .cyphertext (cyphertext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_bit(input logic b);
    sdi = b;
    clk_n(5);
    sck = 1'b1;
    clk_n(5);
    sck = 1'b0;
  endtask

  task automatic send(input logic [255:0] d, input int n);
    load = 1'b1;
    clk_n(5);
    for (int i = 0; i < n; i++) tx_bit(d[255-i]);
    clk_n(5);
    load = 1'b0;
    clk_n(8);
  endtask

  task automatic wait_done(input string name, input logic b);
    for (int i = 0; i < 300 && done_out !== 1'b1; i++) clk_n(1);
    chk({name, "_done"}, done_out, 1'b1);
    chk({name, "_sdo127"}, sdo, b);
  endtask

  task automatic read(input int n, output logic [127:0] w,
                      output logic [3:0] x, output logic d128);
    w = '0;
    x = '0;
    d128 = 1'b1;
    for (int i = 0; i < n; i++) begin
      clk_n(5);
      if (i < 128) w[127-i] = sdo;
      else x[3-(i-128)] = sdo;
      if (i == 128) d128 = done_out;
      sck = 1'b1;
      clk_n(5);
      sck = 1'b0;
    end
    clk_n(6);
  endtask

  // core model: answers each start 20 clk later
  initial begin
    core_done  = 1'b0;
    cyphertext = '0;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        repeat (20) @(negedge clk);
        cyphertext = core_ct;
        core_done  = 1'b1;
        for (int i = 0; i < 100 && done_out !== 1'b1; i++)
          @(negedge clk);
        core_done  = 1'b0;
        cyphertext = '0;
      end
    end
  end

  // start monitor
  initial begin
    logic [RX_BITS-1:0] e;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        if (exp_start_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_start got=1 want=0");
        end else begin
          e = exp_start_q.pop_front();
          chk("start_key", key, e[255:128]);
          chk("start_pt", plaintext, e[127:0]);
        end
      end
    end
  end

  // readout monitor
  initial begin
    logic [BLOCK_BITS-1:0] g;
    forever begin
      @(negedge clk);
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        if (exp_ct_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_ct got=%0h want=none", g);
        end else begin
          chk("ct", g, exp_ct_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    logic [3:0]   x;
    logic         d;
    logic [255:0] kb;
    reset_n = 1'b0;
    sck     = 1'b0;
    sdi     = 1'b0;
    load    = 1'b0;
    core_ct = C1;
    clk_n(3);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_done", done_out, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_key", key, '0);
    chk("rst_pt", plaintext, '0);
    reset_n = 1'b1;
    clk_n(5);

    // nominal round trip
    exp_start_q.push_back({K1, P1});
    exp_ct_q.push_back(C1);
    core_ct = C1;
    send({K1, P1}, 256);
    wait_done("t1", C1[127]);
    read(128, w, x, d);
    got_q.push_back(w);
    chk("t1_done_low", done_out, 1'b0);

    // short load
    send({K2, P2}, 255);
    chk("t2_err", err, 1'b1);
    chk("t2_key_hold", key, K1);
    chk("t2_pt_hold", plaintext, P1);
    chk("t2_done", done_out, 1'b0);
    exp_start_q.push_back({K2, P2});
    exp_ct_q.push_back(C2);
    core_ct = C2;
    send({K2, P2}, 256);
    chk("t2_err_clr", err, 1'b0);
    wait_done("t2", C2[127]);
    read(128, w, x, d);
    got_q.push_back(w);

    // abort during readout
    exp_start_q.push_back({K1, P1});
    core_ct = C1;
    send({K1, P1}, 256);
    wait_done("t3a", C1[127]);
    read(40, w, x, d);
    load = 1'b1;
    clk_n(4);
    chk("t3_abort_done", done_out, 1'b0);
    chk("t3_abort_sdo", sdo, 1'b0);
    exp_start_q.push_back({K2, P2});
    exp_ct_q.push_back(C2);
    core_ct = C2;
    send({K2, P2}, 256);
    wait_done("t3b", C2[127]);
    read(128, w, x, d);
    got_q.push_back(w);

    // spurious core_done in IDLE and RX
    core_done = 1'b1;
    clk_n(10);
    chk("t4_idle_done", done_out, 1'b0);
    chk("t4_idle_sdo", sdo, 1'b0);
    core_done = 1'b0;
    load = 1'b1;
    clk_n(5);
    core_done = 1'b1;
    for (int i = 0; i < 10; i++) tx_bit(1'b1);
    clk_n(3);
    chk("t4_rx_done", done_out, 1'b0);
    core_done = 1'b0;
    load = 1'b0;
    clk_n(8);
    chk("t4_rx_err", err, 1'b1);

    // extra sck pulses after readout
    exp_start_q.push_back({K1, P2});
    exp_ct_q.push_back(C3);
    core_ct = C3;
    send({K1, P2}, 256);
    wait_done("t5", C3[127]);
    read(132, w, x, d);
    got_q.push_back(w);
    chk("t5_extra_bits", x, 4'h0);
    chk("t5_done_128", d, 1'b0);

    // reset in the middle of RX
    kb = {K1, P1};
    load = 1'b1;
    clk_n(5);
    for (int i = 0; i < 100; i++) tx_bit(kb[255-i]);
    reset_n = 1'b0;
    load = 1'b0;
    #1;
    chk("t6_key", key, '0);
    chk("t6_pt", plaintext, '0);
    chk("t6_err", err, 1'b0);
    chk("t6_done", done_out, 1'b0);
    chk("t6_sdo", sdo, 1'b0);
    chk("t6_start", start, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    clk_n(10);
    chk("t6_err_after", err, 1'b0);
    exp_start_q.push_back({K2, P1});
    exp_ct_q.push_back(C1);
    core_ct = C1;
    send({K2, P1}, 256);
    wait_done("t6", C1[127]);
    read(128, w, x, d);
    got_q.push_back(w);

    clk_n(20);
    chk("start_q_empty", exp_start_q.size(), 0);
    chk("ct_q_empty", exp_ct_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
